inst_mem_loader: RTL and testbench
==================================

# inst_mem_loader

Boot-time sequencer and port arbiter for the single-port distributed instruction RAM (synchronous write, asynchronous read). After reset it owns the RAM port, receives a program image as a byte stream from the UART receiver, packs bytes into 32-bit words and writes them sequentially from word address 0. It then hands the RAM port to the core's fetch stage and releases the core from reset. A new load can be requested at any time while the core runs.

## Interface
- ADDR_WIDTH, 10, RAM word-address width; DEPTH = 2**ADDR_WIDTH words
- clk  in  1  system clock, all state on rising edge
- rstn  in  1  asynchronous, active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts byte; transfer when rx_valid && rx_ready
- load_req  in  1  request reload (sampled in RUN and ERR only)
- fetch_addr  in  ADDR_WIDTH  core fetch word address
- fetch_inst  out  32  instruction to core
- fetch_valid  out  1  fetch_inst valid (RUN only)
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_di  out  32  RAM write data
- ram_dout  in  32  RAM asynchronous read data
- core_rstn  out  1  core reset, active-low, registered
- load_done  out  1  level, program loaded and core running
- load_err  out  1  sticky, header word count > DEPTH

## Operation
- States: HDR, DATA, WRITE, RUN, ERR. Reset state HDR.
- HDR: rx_ready=1. Accept 4 bytes, little-endian, into 32-bit count N. On the 4th byte: N==0 -> RUN; N>DEPTH (full 32-bit compare) -> ERR; else store N in ADDR_WIDTH+1 bits, clear word index and byte counter -> DATA.
- DATA: rx_ready=1. 2-bit byte counter; byte k goes to bits [8k+7:8k]. On the 4th byte, register the word -> WRITE.
- WRITE: rx_ready=0, ram_we=1, ram_addr=word index, ram_di=packed word. If index==N-1 -> RUN, else index+1 -> DATA. Index never wraps; max 1023 for DEPTH=1024.
- RUN: rx_ready=0, ram_we=0, ram_addr=fetch_addr (combinational), fetch_inst=ram_dout, fetch_valid=1, core_rstn=1, load_done=1. load_req=1 -> HDR.
- ERR: rx_ready=0, load_err=1, core_rstn=0. load_req=1 -> HDR, clear load_err.
- Outside RUN: ram_addr=registered word index, fetch_inst=0, fetch_valid=0.
- load_req in HDR/DATA/WRITE is ignored. Loads never restart mid-image.
- Bytes presented while rx_ready=0 are not consumed. The source holds them.

## Timing
- Reset values: state HDR, rx_ready=1, ram_we=0, ram_addr=0, ram_di=0, core_rstn=0, load_done=0, load_err=0, fetch_valid=0, fetch_inst=0, counters 0.
- Reset asserted mid-load: all outputs return to reset values immediately (async). RAM contents already written are left as-is. The next image starts at address 0.
- One byte per cycle maximum. A word costs at least 5 cycles (4 DATA + 1 WRITE).
- core_rstn, load_done and fetch_valid rise in the first RUN cycle, one cycle after the final WRITE or after the 4th header byte when N==0.
- load_req sampled high in RUN: the next cycle is HDR, with core_rstn=0, load_done=0, fetch_valid=0.
- Fetch read latency: 0 cycles (fetch_addr -> fetch_inst combinational through the async RAM).
- load_err rises the cycle after the 4th header byte.

## Test plan
- Reset, then stream 02 00 00 00, 13 00 00 00, 93 00 10 00 -> ram_we pulses: addr 0 with 0x00000013, then addr 1 with 0x00100093. Next cycle core_rstn=1 and load_done=1. fetch_addr=1 returns fetch_inst=0x00100093 the same cycle.
- Header 00 00 00 00 -> no ram_we. RUN and core_rstn=1 in the cycle after the 4th byte.
- Header 01 04 00 00 (N=1025) -> ERR, load_err=1, rx_ready=0, core_rstn=0. Pulse load_req -> HDR, load_err=0, rx_ready=1.
- Full 1024-word image with random rx_valid gaps -> 1024 writes at addresses 0..1023 in order, no wrap, no dropped or duplicated bytes. rx_ready=0 on each WRITE cycle, and a byte held across it is consumed in the next DATA cycle.
- Assert rstn low during DATA, after 2 words are written -> all outputs at reset values. A fresh 1-word image is written to addr 0.
- In RUN, pulse load_req -> core_rstn=0 and fetch_valid=0 next cycle. A new image reloads and RUN resumes.

Source files
------------

// File: rtl/inst_mem_loader.sv
// Boot loader and port arbiter for the single-port instruction RAM.
// After reset it receives a byte stream: a 4-byte little-endian word count N,
// then N little-endian 32-bit words. Words are written to RAM from address 0.
// The RAM port is then handed to the core's fetch stage and the core leaves reset.
// A reload may be requested from RUN or ERR.
module inst_mem_loader #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    // Byte stream from the UART receiver
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    // Reload request from the system
    input  logic                  load_req,
    // Core fetch side
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [31:0]           fetch_inst,
    output logic                  fetch_valid,
    // RAM port
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_di,
    input  logic [31:0]           ram_dout,
    // Status and core control
    output logic                  core_rstn,
    output logic                  load_done,
    output logic                  load_err
);

    // Depth held in 33 bits so the header compare covers the full 32-bit count.
    localparam logic [32:0] DEPTH_W = 33'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] ONE_CNT = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        StHdr,
        StData,
        StWrite,
        StRun,
        StErr
    } state_t;

    state_t                state_q;
    logic [1:0]            byte_cnt_q;
    logic [23:0]           hdr_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [31:0]           word_q;
    logic                  core_rstn_q;
    logic                  load_done_q;
    logic                  load_err_q;

    logic [31:0]           hdr_word;
    logic                  accept;
    logic                  last_word;
    logic                  in_run;

    // Full header count as seen on the cycle its final byte arrives.
    assign hdr_word  = {rx_data, hdr_q};
    assign accept    = rx_valid && rx_ready;
    // count_q is never 0 in DATA/WRITE, so count_q-1 is a valid index.
    assign last_word = ({1'b0, idx_q} == (count_q - ONE_CNT));
    assign in_run    = (state_q == StRun);

    // Sequencer: header capture, word packing, RAM writes and run/error hand-off.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StHdr;
            byte_cnt_q  <= 2'd0;
            hdr_q       <= 24'd0;
            count_q     <= '0;
            idx_q       <= '0;
            word_q      <= 32'd0;
            core_rstn_q <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StHdr: begin
                    if (accept) begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        case (byte_cnt_q)
                            2'd0: hdr_q[7:0]   <= rx_data;
                            2'd1: hdr_q[15:8]  <= rx_data;
                            2'd2: hdr_q[23:16] <= rx_data;
                            default: begin
                                if (hdr_word == 32'd0) begin
                                    // Empty image: start the core straight away.
                                    state_q     <= StRun;
                                    core_rstn_q <= 1'b1;
                                    load_done_q <= 1'b1;
                                end else if ({1'b0, hdr_word} > DEPTH_W) begin
                                    state_q    <= StErr;
                                    load_err_q <= 1'b1;
                                end else begin
                                    state_q    <= StData;
                                    count_q    <= hdr_word[ADDR_WIDTH:0];
                                    idx_q      <= '0;
                                    byte_cnt_q <= 2'd0;
                                end
                            end
                        endcase
                    end
                end
                StData: begin
                    if (accept) begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        case (byte_cnt_q)
                            2'd0: word_q[7:0]   <= rx_data;
                            2'd1: word_q[15:8]  <= rx_data;
                            2'd2: word_q[23:16] <= rx_data;
                            default: begin
                                word_q[31:24] <= rx_data;
                                state_q       <= StWrite;
                            end
                        endcase
                    end
                end
                StWrite: begin
                    if (last_word) begin
                        state_q     <= StRun;
                        core_rstn_q <= 1'b1;
                        load_done_q <= 1'b1;
                    end else begin
                        // Index stops at N-1, so it never wraps.
                        idx_q   <= idx_q + 1'b1;
                        state_q <= StData;
                    end
                end
                StRun: begin
                    if (load_req) begin
                        state_q     <= StHdr;
                        core_rstn_q <= 1'b0;
                        load_done_q <= 1'b0;
                        byte_cnt_q  <= 2'd0;
                        idx_q       <= '0;
                    end
                end
                StErr: begin
                    if (load_req) begin
                        state_q    <= StHdr;
                        load_err_q <= 1'b0;
                        byte_cnt_q <= 2'd0;
                        idx_q      <= '0;
                    end
                end
                default: state_q <= StHdr;
            endcase
        end
    end

    // Port arbitration: fetch owns the RAM address only in RUN.
    always_comb begin
        rx_ready    = (state_q == StHdr) || (state_q == StData);
        ram_we      = (state_q == StWrite);
        ram_di      = word_q;
        fetch_valid = in_run;
        ram_addr    = idx_q;
        fetch_inst  = 32'd0;
        if (in_run) begin
            ram_addr   = fetch_addr;
            fetch_inst = ram_dout;
        end
    end

    assign core_rstn = core_rstn_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader with a behavioural async-read RAM.
// Expected RAM writes are queued as words are sent and checked as ram_we fires.
module tb_inst_mem_loader;

    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rstn;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          load_req;
    logic [AW-1:0] fetch_addr;
    logic [31:0]   fetch_inst;
    logic          fetch_valid;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_di;
    logic [31:0]   ram_dout;
    logic          core_rstn;
    logic          load_done;
    logic          load_err;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] img [0:DEPTH-1];
    logic [31:0] mem [0:DEPTH-1];
    int          checks = 0;
    int          errors = 0;
    int          nwrites = 0;

    always #5 clk = ~clk;

    // RAM model: synchronous write, asynchronous read.
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_di;
    assign ram_dout = mem[ram_addr];

    inst_mem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .load_req    (load_req),
        .fetch_addr  (fetch_addr),
        .fetch_inst  (fetch_inst),
        .fetch_valid (fetch_valid),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_di      (ram_di),
        .ram_dout    (ram_dout),
        .core_rstn   (core_rstn),
        .load_done   (load_done),
        .load_err    (load_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and check any RAM write against the scoreboard.
    task automatic cycle();
        wr_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("no_write", {31'd0, ram_we}, 32'd0);
        end else if (ram_we) begin
            e = exp_q.pop_front();
            nwrites++;
            chk("wr_addr", 32'(ram_addr), 32'(e.addr));
            chk("wr_data", ram_di, e.data);
            chk("wr_rx_ready", {31'd0, rx_ready}, 32'd0);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        logic acc;
        int   guard;
        if (gaps) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 2)) cycle();
        end
        rx_data  = b;
        rx_valid = 1'b1;
        guard    = 0;
        do begin
            #1;
            acc = rx_ready;
            cycle();
            guard++;
        end while (!acc && guard < 50);
        if (!acc) chk("byte_timeout", {31'd0, acc}, 32'd1);
        rx_valid = 1'b0;
    endtask

    task automatic send_header(input logic [31:0] n, input bit gaps);
        for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8], gaps);
    endtask

    task automatic send_word(input int a, input logic [31:0] w, input bit gaps);
        wr_t e;
        e.addr = AW'(a);
        e.data = w;
        exp_q.push_back(e);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
    endtask

    task automatic load_image(input int n, input bit gaps);
        send_header(32'(n), gaps);
        for (int i = 0; i < n; i++) send_word(i, img[i], gaps);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd1);
        chk({tag, "_ram_we"}, {31'd0, ram_we}, 32'd0);
        chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_ram_di"}, ram_di, 32'd0);
        chk({tag, "_core_rstn"}, {31'd0, core_rstn}, 32'd0);
        chk({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
        chk({tag, "_load_err"}, {31'd0, load_err}, 32'd0);
        chk({tag, "_fetch_valid"}, {31'd0, fetch_valid}, 32'd0);
        chk({tag, "_fetch_inst"}, fetch_inst, 32'd0);
    endtask

    task automatic chk_run(input string tag, input logic exp);
        chk({tag, "_core_rstn"}, {31'd0, core_rstn}, {31'd0, exp});
        chk({tag, "_load_done"}, {31'd0, load_done}, {31'd0, exp});
        chk({tag, "_fetch_valid"}, {31'd0, fetch_valid}, {31'd0, exp});
    endtask

    task automatic pulse_load_req();
        load_req = 1'b1;
        cycle();
        load_req = 1'b0;
    endtask

    initial begin
        int w0;
        rstn       = 1'b0;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        load_req   = 1'b0;
        fetch_addr = '0;
        #2;
        chk_reset_outputs("reset");
        #15 rstn = 1'b1;
        cycle();

        // Two-word image.
        img[0] = 32'h0000_0013;
        img[1] = 32'h0010_0093;
        load_image(2, 1'b0);
        chk_run("two_word_write", 1'b0);
        cycle();
        chk_run("two_word_run", 1'b1);
        fetch_addr = AW'(1);
        #1 chk("fetch1", fetch_inst, 32'h0010_0093);
        fetch_addr = AW'(0);
        #1 chk("fetch0", fetch_inst, 32'h0000_0013);
        chk("two_word_count", 32'(nwrites), 32'd2);

        // Reload from RUN with an empty image.
        pulse_load_req();
        chk_run("reload_hdr", 1'b0);
        chk("reload_rx_ready", {31'd0, rx_ready}, 32'd1);
        send_header(32'd0, 1'b0);
        chk_run("empty_run", 1'b1);
        cycle();
        chk("empty_count", 32'(nwrites), 32'd2);

        // Oversized header goes to ERR; load_err is sticky until reload.
        pulse_load_req();
        send_header(32'd1025, 1'b0);
        chk("err_load_err", {31'd0, load_err}, 32'd1);
        chk("err_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("err_core_rstn", {31'd0, core_rstn}, 32'd0);
        cycle();
        cycle();
        chk("err_sticky", {31'd0, load_err}, 32'd1);
        pulse_load_req();
        chk("err_clear", {31'd0, load_err}, 32'd0);
        chk("err_hdr_rx_ready", {31'd0, rx_ready}, 32'd1);

        // Full-depth image with random valid gaps.
        for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
        w0 = nwrites;
        load_image(DEPTH, 1'b1);
        cycle();
        chk_run("full_run", 1'b1);
        chk("full_count", 32'(nwrites - w0), 32'(DEPTH));
        fetch_addr = AW'(DEPTH - 1);
        #1 chk("full_fetch_last", fetch_inst, img[DEPTH-1]);
        fetch_addr = AW'(517);
        #1 chk("full_fetch_mid", fetch_inst, img[517]);

        // Async reset mid-image, load_req ignored while loading.
        pulse_load_req();
        send_header(32'd5, 1'b0);
        send_word(0, 32'hA5A5_0001, 1'b0);
        load_req = 1'b1;
        send_word(1, 32'hA5A5_0002, 1'b0);
        load_req = 1'b0;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        chk("mid_rx_ready", {31'd0, rx_ready}, 32'd1);
        chk("mid_ram_addr", 32'(ram_addr), 32'd2);
        #2 rstn = 1'b0;
        #1 chk_reset_outputs("midreset");
        exp_q.delete();
        @(negedge clk) rstn = 1'b1;
        img[0] = 32'hCAFE_F00D;
        load_image(1, 1'b0);
        cycle();
        chk_run("fresh_run", 1'b1);
        fetch_addr = AW'(0);
        #1 chk("fresh_fetch0", fetch_inst, 32'hCAFE_F00D);
        fetch_addr = AW'(1);
        #1 chk("fresh_fetch1", fetch_inst, 32'hA5A5_0002);

        // Reload from RUN and resume.
        pulse_load_req();
        chk_run("reload2_hdr", 1'b0);
        img[0] = 32'h1234_5678;
        img[1] = 32'h9ABC_DEF0;
        img[2] = 32'h0BAD_BEEF;
        load_image(3, 1'b1);
        cycle();
        chk_run("reload2_run", 1'b1);
        fetch_addr = AW'(2);
        #1 chk("reload2_fetch2", fetch_inst, 32'h0BAD_BEEF);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
